// File: rtl/dm_lsu_pkg.sv
// dm_lsu shared package: DMType encodings and FSM state constants.
// Optional build macro for the whole slice: DM_LSU_TIMEOUT_EN.
package dm_pkg;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

endpackage

// File: rtl/dm_lsu_if.sv
// dm_lsu interfaces: core request/response side and data-memory bus side.
// No configuration macros are used in this file.
interface dm_core_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_dmtype;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_dmtype,
    output req_addr, req_wdata,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_dmtype,
    input  req_addr, req_wdata,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );
endinterface

interface dm_bus_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr,
    output mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr,
    input  mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/dm_align.sv
// dm_align: byte-lane enables, store replication, load extraction and
// extension, and misalign/illegal detection (purely combinational).
module dm_align
  import dm_pkg::*;
(
  input  logic [2:0]  st_dmtype,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  input  logic [2:0]  ld_dmtype,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic        bad
);

  logic is_w, is_h, is_b;
  logic [31:0] sh;

  assign is_w = (st_dmtype == DM_WORD);
  assign is_h = (st_dmtype == DM_HALF)
             || (st_dmtype == DM_HALF_U);
  assign is_b = (st_dmtype == DM_BYTE)
             || (st_dmtype == DM_BYTE_U);

  always_comb begin
    be    = 4'b0000;
    wdata = st_wdata;
    bad   = 1'b1;
    unique case (1'b1)
      is_w: begin
        be    = 4'b1111;
        bad   = (st_off != 2'b00);
      end
      is_h: begin
        be    = 4'b0011 << st_off;
        wdata = {2{st_wdata[15:0]}};
        bad   = st_off[0];
      end
      is_b: begin
        be    = 4'b0001 << st_off;
        wdata = {4{st_wdata[7:0]}};
        bad   = 1'b0;
      end
      default: ;
    endcase
  end

  assign sh = ld_rdata >> {ld_off, 3'b000};

  always_comb begin
    ldata = sh;
    case (ld_dmtype)
      DM_HALF:   ldata = {{16{sh[15]}}, sh[15:0]};
      DM_HALF_U: ldata = {16'h0, sh[15:0]};
      DM_BYTE:   ldata = {{24{sh[7]}}, sh[7:0]};
      DM_BYTE_U: ldata = {24'h0, sh[7:0]};
      default:   ldata = sh;
    endcase
  end

endmodule

// File: rtl/dm_lsu.sv
// dm_lsu: single-access load/store unit with req/gnt/rvalid bus handshake.
// DM_LSU_TIMEOUT_EN adds an rvalid timeout (TIMEOUT cycles) in WAIT.
module dm_lsu
  import dm_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rstn,
  dm_core_if.slave   core,
  dm_bus_if.master   bus,
  output logic       busy
);

  logic [1:0]  state, state_n;
  logic [2:0]  r_dt;
  logic [1:0]  r_off;
  logic        r_err;
  logic [3:0]  a_be;
  logic [31:0] a_wd, a_ld;
  logic        a_bad;
  logic        accept;
  logic        to_hit;

  dm_align u_align (
    .st_dmtype (core.req_dmtype),
    .st_off    (core.req_addr[1:0]),
    .st_wdata  (core.req_wdata),
    .ld_dmtype (r_dt),
    .ld_off    (r_off),
    .ld_rdata  (bus.mem_rdata),
    .be        (a_be),
    .wdata     (a_wd),
    .ldata     (a_ld),
    .bad       (a_bad)
  );

  assign accept = core.req_valid && (state == S_IDLE);

`ifdef DM_LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] cnt;

  assign to_hit = (state == S_WAIT) && !bus.mem_rvalid
               && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      cnt <= '0;
    else if (state == S_WAIT && !bus.mem_rvalid && !to_hit)
      cnt <= cnt + 1'b1;
    else
      cnt <= '0;
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (accept) state_n = a_bad ? S_RESP : S_REQ;
      S_REQ:  if (bus.mem_gnt) state_n = S_WAIT;
      S_WAIT: if (bus.mem_rvalid || to_hit) state_n = S_RESP;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= S_IDLE;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_be     <= '0;
      bus.mem_wdata  <= '0;
      r_dt           <= '0;
      r_off          <= '0;
      r_err          <= 1'b0;
      core.rsp_rdata <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        r_err <= a_bad;
        if (!a_bad) begin
          bus.mem_we    <= core.req_we;
          bus.mem_addr  <= {core.req_addr[31:2], 2'b00};
          bus.mem_be    <= a_be;
          bus.mem_wdata <= a_wd;
          r_dt          <= core.req_dmtype;
          r_off         <= core.req_addr[1:0];
        end
      end
      // store acks leave the last load result untouched
      if (state == S_WAIT && bus.mem_rvalid) begin
        if (!bus.mem_we) core.rsp_rdata <= a_ld;
      end else if (to_hit) begin
        r_err <= 1'b1;
      end
    end
  end

  assign core.req_ready = (state == S_IDLE);
  assign core.rsp_valid = (state == S_RESP);
  assign core.rsp_err   = r_err && (state == S_RESP);
  assign bus.mem_req    = (state == S_REQ);
  assign busy           = (state != S_IDLE);

endmodule

// File: doc/dm_lsu.md
# dm_lsu

Load/store unit between the single-cycle core's decoded memory controls (MemWrite, DMType, ALU address, rs2 data) and a word-wide data-memory bus. It accepts one access at a time, performs byte-lane alignment, write-data replication and load sign/zero extension, and runs a request/grant/response handshake on the bus. It also flags misaligned or illegal accesses without touching the bus. It returns one response pulse per accepted request.

## Interface
- TIMEOUT, 16: cycles waited for `mem_rvalid` before an error response (used only with the timeout feature).
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  core access request
- req_ready  out  1  high only in IDLE; accept = req_valid & req_ready
- req_we  in  1  1 = store (MemWrite), 0 = load
- req_dmtype  in  3  000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned; 101–111 illegal
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bits significant)
- rsp_valid  out  1  one-cycle completion pulse; no backpressure
- rsp_rdata  out  32  extended load data; holds last value
- rsp_err  out  1  valid with rsp_valid
- busy  out  1  state != IDLE
- mem_req  out  1  bus request, held until mem_gnt
- mem_we  out  1  bus write
- mem_addr  out  32  {req_addr[31:2], 2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  replicated store data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  response (load data or write ack)
- mem_rdata  in  32  read word

## Operation
- FSM: IDLE, REQ, WAIT, RESP.
- IDLE to REQ: on accept of a legal, aligned request. Request fields are registered.
- IDLE to RESP with err=1: on accept of a request that is misaligned (word with addr[1:0]≠0, half with addr[0]≠0) or has illegal dmtype. No bus activity.
- REQ: mem_req=1, bus outputs stable. Moves to WAIT on mem_gnt.
- WAIT: moves to RESP on mem_rvalid, capturing mem_rdata.
- RESP: rsp_valid=1 for one cycle, then IDLE.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
- Write data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Loads: shift mem_rdata right by 8·addr[1:0], then sign-extend (000, 001, 011) or zero-extend (010, 100) to 32 bits.
- Stores complete on mem_rvalid. Read data is ignored and rsp_rdata is unchanged.
- mem_rvalid outside WAIT and mem_gnt outside REQ are ignored.

## Timing
- Reset: state IDLE; req_ready=1; all other outputs 0 (rsp_rdata, mem_addr, mem_be and mem_wdata included).
- All outputs are registered or decoded from state.
- Minimum latency, with gnt in the first REQ cycle and rvalid one cycle later:
  - accept at cycle 0
  - mem_req at cycle 1
  - rvalid at cycle 2
  - rsp_valid at cycle 3
- Error path: rsp_valid at cycle 1.
- The bus guarantees mem_rvalid no earlier than the cycle after mem_gnt.
- Reset mid-operation: immediate return to IDLE. The outstanding bus transaction is abandoned and a late rvalid is ignored.

## Configuration
- `DM_LSU_TIMEOUT_EN` defined:
  - A counter runs in WAIT.
  - If TIMEOUT cycles pass without mem_rvalid, go to RESP with rsp_err=1 and rsp_rdata unchanged.
  - The counter clears on leaving WAIT.
- Undefined: no counter; WAIT is held indefinitely.

## Structure
- Shared package `dm_pkg`: DMType constants (DM_WORD, DM_HALF, DM_HALF_U, DM_BYTE, DM_BYTE_U) and the FSM state encoding.
- Sub-module `dm_align` (combinational): computes be, wdata replication, load extraction/extension and the misalign/illegal flag.

## Test plan
- sw addr 0x104, data 0xDEADBEEF, gnt immediate, rvalid next cycle -> mem_addr 0x104, be 1111, wdata 0xDEADBEEF, rsp_valid 3 cycles after accept, err 0.
- lb addr 0x103, rdata 0x80FF1234 -> rsp_rdata 0xFFFFFF80. Same access as lbu -> 0x00000080.
- sh addr 0x102, wdata 0x0000ABCD -> be 1100, mem_wdata 0xABCDABCD. lh/lhu addr 0x102, rdata 0xABCD0000 -> 0xFFFFABCD / 0x0000ABCD.
- lw addr 0x101 -> rsp_valid with err=1 one cycle after accept, mem_req never asserted. dmtype 111 -> same.
- gnt delayed 5 cycles -> mem_req and addr/be/wdata stable throughout, req_ready=0, busy=1. rvalid pulsed during REQ -> ignored.
- With `DM_LSU_TIMEOUT_EN` and TIMEOUT=8, rvalid withheld -> err response after 8 WAIT cycles. Separately, rstn pulsed in WAIT -> IDLE immediately, and a subsequent rvalid produces no rsp_valid.
